// File: rtl/btn_debounce.sv
// btn_debounce
// Push-button conditioning for the LED pattern logic. Each channel
// synchronises its raw pin to CLK and filters contact bounce. It then
// emits a clean level plus single-cycle press, release, short-click and
// long-press events.
//
// Ports
//   CLK          system clock, all state changes on the rising edge
//   RST          asynchronous active-high reset
//   BTN_RAW      raw asynchronous pins (polarity set by ACTIVE_LOW)
//   BTN_LEVEL    debounced level, 1 = pressed
//   BTN_PRESS    1-cycle pulse in the cycle BTN_LEVEL first reads 1
//   BTN_RELEASE  1-cycle pulse in the cycle BTN_LEVEL first reads 0
//   BTN_SHORT    1-cycle pulse with RELEASE when no long event fired
//   BTN_LONG     1-cycle pulse once per press, LONG_CYCLES-1 edges after PRESS
module btn_debounce #(
  parameter int N_BTN       = 3,
  parameter bit ACTIVE_LOW  = 1'b1,
  parameter int DEB_CYCLES  = 120000,
  parameter int LONG_CYCLES = 6000000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_BTN-1:0] BTN_RAW,
  output logic [N_BTN-1:0] BTN_LEVEL,
  output logic [N_BTN-1:0] BTN_PRESS,
  output logic [N_BTN-1:0] BTN_RELEASE,
  output logic [N_BTN-1:0] BTN_SHORT,
  output logic [N_BTN-1:0] BTN_LONG
);

  localparam int DW = $clog2(DEB_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_PRE  = HW'(LONG_CYCLES - 2);

  typedef enum logic [1:0] {
    ST_UP   = 2'd0,
    ST_DOWN = 2'd1,
    ST_LONG = 2'd2
  } state_e;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic          s1_q, s2_q;
    logic          level_q, level_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] hold_q, hold_d;
    state_e        state_q, state_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic          short_q, short_d;
    logic          long_q, long_d;
    logic          rise, fall;

    // Debounce: the level flips only after DEB_CYCLES consecutive cycles in
    // which the synchronised input disagrees with it. rise/fall mark the edge
    // on which that flip is registered, so events line up with BTN_LEVEL.
    always_comb begin
      level_d = level_q;
      cnt_d   = cnt_q;
      rise    = 1'b0;
      fall    = 1'b0;
      if (s2_q == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == DEB_LAST) begin
        level_d = ~level_q;
        cnt_d   = '0;
        rise    = ~level_q;
        fall    = level_q;
      end else begin
        cnt_d = cnt_q + DW'(1);
      end
    end

    // Press FSM. In DOWN a fall is checked before the long threshold so a
    // release landing on the threshold cycle is reported as a short click.
    always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      short_d = 1'b0;
      long_d  = 1'b0;
      case (state_q)
        ST_UP: begin
          if (rise) begin
            press_d = 1'b1;
            hold_d  = '0;
            state_d = ST_DOWN;
          end
        end
        ST_DOWN: begin
          if (fall) begin
            rel_d   = 1'b1;
            short_d = 1'b1;
            state_d = ST_UP;
          end else if (hold_q == HOLD_PRE) begin
            long_d  = 1'b1;
            hold_d  = HOLD_LAST;
            state_d = ST_LONG;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
        ST_LONG: begin
          // hold counter frozen here: one long event per press
          if (fall) begin
            rel_d   = 1'b1;
            state_d = ST_UP;
          end
        end
        default: state_d = ST_UP;
      endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        s1_q    <= 1'b0;
        s2_q    <= 1'b0;
        level_q <= 1'b0;
        cnt_q   <= '0;
        hold_q  <= '0;
        state_q <= ST_UP;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        short_q <= 1'b0;
        long_q  <= 1'b0;
      end else begin
        s1_q    <= BTN_RAW[i] ^ ACTIVE_LOW;
        s2_q    <= s1_q;
        level_q <= level_d;
        cnt_q   <= cnt_d;
        hold_q  <= hold_d;
        state_q <= state_d;
        press_q <= press_d;
        rel_q   <= rel_d;
        short_q <= short_d;
        long_q  <= long_d;
      end
    end

    assign BTN_LEVEL[i]   = level_q;
    assign BTN_PRESS[i]   = press_q;
    assign BTN_RELEASE[i] = rel_q;
    assign BTN_SHORT[i]   = short_q;
    assign BTN_LONG[i]    = long_q;
  end

endmodule

// File: tb/tb_btn_debounce.sv
module tb_btn_debounce;

  localparam int N   = 3;
  localparam int DEB = 4;
  localparam int LNG = 20;

  logic         clk;
  logic         rst;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_short, btn_long;

  btn_debounce #(
    .N_BTN      (N),
    .ACTIVE_LOW (1'b1),
    .DEB_CYCLES (DEB),
    .LONG_CYCLES(LNG)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .BTN_RAW    (btn_raw),
    .BTN_LEVEL  (btn_level),
    .BTN_PRESS  (btn_press),
    .BTN_RELEASE(btn_release),
    .BTN_SHORT  (btn_short),
    .BTN_LONG   (btn_long)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
    logic [N-1:0] rel;
    logic [N-1:0] sht;
    logic [N-1:0] lng;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   edge_n   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, req, edge_n);
    end
  endtask

  // Reference model: the level follows the pressed sense of the pin once the
  // two-cycle-delayed samples have disagreed with it for DEB consecutive
  // edges; events are derived from edge distances to the press.
  bit hist [N][DEB+2];
  bit m_lvl [N];
  int m_pedge [N];

  always @(posedge clk) begin
    exp_t e;
    bit   all_diff;
    edge_n++;
    e = '0;
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        for (int k = 0; k < DEB + 2; k++) hist[i][k] = 1'b0;
        m_lvl[i] = 1'b0;
      end else begin
        all_diff = 1'b1;
        for (int k = 1; k <= DEB; k++)
          if (hist[i][k] == m_lvl[i]) all_diff = 1'b0;
        for (int k = DEB + 1; k > 0; k--) hist[i][k] = hist[i][k-1];
        hist[i][0] = ~btn_raw[i];
        if (all_diff) begin
          m_lvl[i] = ~m_lvl[i];
          if (m_lvl[i]) begin
            e.prs[i]   = 1'b1;
            m_pedge[i] = edge_n;
          end else begin
            e.rel[i] = 1'b1;
            if (edge_n - m_pedge[i] <= LNG - 1) e.sht[i] = 1'b1;
          end
        end else if (m_lvl[i] && (edge_n - m_pedge[i] == LNG - 1)) begin
          e.lng[i] = 1'b1;
        end
      end
      e.lvl[i] = m_lvl[i];
    end
    exp_q.push_back(e);
  end

  // Monitor: compares every cycle's outputs and logs observed pulses.
  int seen_press [N];
  int seen_rel   [N];
  int seen_long  [N];
  int n_press    [N];
  int n_rel      [N];
  int n_short    [N];
  int n_long     [N];

  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {btn_level, btn_press, btn_release, btn_short, btn_long};
      check("outputs{lvl,prs,rel,sht,lng}", 32'(a), 32'(e));
      for (int i = 0; i < N; i++) begin
        if (btn_press[i])   begin seen_press[i] = edge_n; n_press[i]++; end
        if (btn_release[i]) begin seen_rel[i]   = edge_n; n_rel[i]++;   end
        if (btn_short[i])   n_short[i]++;
        if (btn_long[i])    begin seen_long[i]  = edge_n; n_long[i]++;  end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    int e0, p0, r0, s0, l0;
    for (int i = 0; i < N; i++) begin
      seen_press[i] = 0; seen_rel[i] = 0; seen_long[i] = 0;
      n_press[i] = 0; n_rel[i] = 0; n_short[i] = 0; n_long[i] = 0;
    end
    rst     = 1'b1;
    btn_raw = '1;
    step(3);
    rst = 1'b0;
    step(10);
    check("no_events_after_reset", 32'(n_press[0] + n_press[1] + n_press[2]), 32'd0);

    // clean short press on channel 0
    btn_raw[0] = 1'b0;
    e0 = edge_n;
    step(10);
    check("short_press_latency", 32'(seen_press[0] - e0), 32'd6);
    btn_raw[0] = 1'b1;
    e0 = edge_n;
    step(10);
    check("short_release_latency", 32'(seen_rel[0] - e0), 32'd6);
    check("short_click_count", 32'(n_short[0]), 32'd1);
    check("short_no_long", 32'(n_long[0]), 32'd0);

    // bounce on channel 1, then settles released
    p0 = n_press[1];
    for (int k = 0; k < 10; k++) begin
      btn_raw[1] = k[0];
      step(2);
    end
    btn_raw[1] = 1'b1;
    step(12);
    check("bounce_no_press", 32'(n_press[1] - p0), 32'd0);
    // same bounce, then settles pressed
    for (int k = 0; k < 10; k++) begin
      btn_raw[1] = k[0];
      step(2);
    end
    btn_raw[1] = 1'b0;
    e0 = edge_n;
    step(10);
    check("bounce_then_press_count", 32'(n_press[1] - p0), 32'd1);
    check("bounce_then_press_latency", 32'(seen_press[1] - e0), 32'd6);
    btn_raw[1] = 1'b1;
    step(10);

    // long press on channel 2
    s0 = n_short[2]; l0 = n_long[2]; r0 = n_rel[2];
    btn_raw[2] = 1'b0;
    step(40);
    btn_raw[2] = 1'b1;
    step(10);
    check("long_count", 32'(n_long[2] - l0), 32'd1);
    check("long_delay", 32'(seen_long[2] - seen_press[2]), 32'd19);
    check("long_release", 32'(n_rel[2] - r0), 32'd1);
    check("long_no_short", 32'(n_short[2] - s0), 32'd0);

    // boundary: fall lands on the hold-count-19 cycle -> short, no long
    s0 = n_short[2]; l0 = n_long[2];
    btn_raw[2] = 1'b0;
    step(19);
    btn_raw[2] = 1'b1;
    step(10);
    check("boundary_short", 32'(n_short[2] - s0), 32'd1);
    check("boundary_no_long", 32'(n_long[2] - l0), 32'd0);
    // one cycle later -> long then release, no short
    s0 = n_short[2]; l0 = n_long[2];
    btn_raw[2] = 1'b0;
    step(20);
    btn_raw[2] = 1'b1;
    step(10);
    check("boundary_plus1_long", 32'(n_long[2] - l0), 32'd1);
    check("boundary_plus1_no_short", 32'(n_short[2] - s0), 32'd0);
    check("boundary_plus1_order", 32'(seen_rel[2] - seen_long[2]), 32'd1);

    // reset mid-press, button held throughout
    btn_raw[0] = 1'b0;
    step(12);
    r0 = n_rel[0]; p0 = n_press[0];
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    e0 = edge_n;
    step(10);
    check("reset_mid_press_no_release", 32'(n_rel[0] - r0), 32'd0);
    check("reset_mid_press_fresh_press", 32'(seen_press[0] - e0), 32'd6);
    check("reset_mid_press_press_count", 32'(n_press[0] - p0), 32'd1);
    btn_raw[0] = 1'b1;
    step(10);

    // all channels together
    btn_raw = '0;
    step(30);
    btn_raw = '1;
    step(12);

    // randomized stretches, with occasional reset
    for (int j = 0; j < 200; j++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        step($urandom_range(1, 3));
        rst = 1'b0;
      end
      btn_raw = N'($urandom);
      step($urandom_range(1, 28));
    end
    btn_raw = '1;
    step(20);

    check("scoreboard_drained", 32'(exp_q.size() <= 1), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Per-button input conditioning stage sitting directly upstream of the LED blink/pattern logic on the iCEBreaker. It synchronises the raw push-button pins to `CLK` and filters contact bounce. It then emits clean levels and single-cycle press, release, short-click and long-press events, which downstream LED logic consumes as mode/rate controls.

## Interface
- `N_BTN`, default 3: number of independent button channels.
- `ACTIVE_LOW`, default 1: 1 = raw pins read 0 when pressed (board `BTN_N` style); 0 = active-high pins.
- `DEB_CYCLES`, default 120000: consecutive stable cycles required to accept a new level (10 ms at 12 MHz); legal range ≥ 2.
- `LONG_CYCLES`, default 6000000: cycles of accepted press before the long-press event (500 ms); must be > 1.
- `CLK` input 1: 12 MHz system clock; all state changes on rising edge.
- `RST` input 1: asynchronous, active-high reset.
- `BTN_RAW` input N_BTN: raw, asynchronous button pins.
- `BTN_LEVEL` output N_BTN: debounced level, 1 = pressed.
- `BTN_PRESS` output N_BTN: 1-cycle pulse when the level goes 0→1.
- `BTN_RELEASE` output N_BTN: 1-cycle pulse when the level goes 1→0.
- `BTN_SHORT` output N_BTN: 1-cycle pulse on release if no long event fired during that press.
- `BTN_LONG` output N_BTN: 1-cycle pulse once per press, when the press has lasted LONG_CYCLES.

## Operation
- Channels are fully independent, with identical logic instantiated per bit. No cross-channel interaction.
- **Polarity:** `p = BTN_RAW[i] ^ ACTIVE_LOW`, so p=1 means pressed.
- **Synchroniser:** two flops, `s1 <= p` then `s2 <= s1`. Only `s2` is used downstream.
- **Debounce counter:** width clog2(DEB_CYCLES).
  - If `s2 == BTN_LEVEL`: the counter clears to 0.
  - Otherwise, if `cnt == DEB_CYCLES-1`: `BTN_LEVEL` toggles and the counter clears.
  - Otherwise the counter increments.
  - Any single-cycle return of `s2` to the current level restarts the count.
- **Press FSM per channel.**
  - **UP:** on the debounced rise, pulse `BTN_PRESS`, clear the hold counter, go to DOWN.
  - **DOWN:** the hold counter increments each cycle.
    - When it reaches LONG_CYCLES-1: pulse `BTN_LONG`, go to LONG.
    - On a debounced fall first: pulse `BTN_RELEASE` and `BTN_SHORT`, go to UP.
  - **LONG:** the hold counter is frozen (no wrap, no repeat). On a debounced fall: pulse `BTN_RELEASE` only, go to UP.
- Hold counter width is clog2(LONG_CYCLES). It never wraps.
- Event outputs are registered and high for exactly one cycle. The PRESS pulse is in the same cycle `BTN_LEVEL` first reads 1; the RELEASE pulse is in the same cycle it first reads 0.

## Timing
- **Reset values:** `s1`/`s2` = 0 (released), `BTN_LEVEL` = 0, all counters 0, FSM = UP, all pulses 0. Asynchronous assert; deassert is sampled on the next `CLK` edge.
- **Reset mid-press:** everything returns to the reset values and no RELEASE/SHORT is emitted. If the button is still held after reset, a fresh PRESS follows after the normal latency.
- **Latency:** a raw change held stable reaches `s2` after 2 edges. `BTN_LEVEL` changes DEB_CYCLES edges after that, for a total of DEB_CYCLES+2 edges from the first sampling edge.
- **Long-press timing:** the LONG pulse occurs LONG_CYCLES-1 edges after the PRESS pulse.
- **Minimum accepted press:** a press stable for DEB_CYCLES cycles at `s2` is accepted. Glitches shorter than DEB_CYCLES cycles produce no event.
- **Simultaneous events:**
  - Release in the same cycle the hold count reaches LONG_CYCLES-1: the fall wins. Emit RELEASE+SHORT, no LONG.
  - PRESS and LONG never coincide.
  - Multiple channels may pulse in the same cycle.

## Test plan
Bench parameters: N_BTN=3, ACTIVE_LOW=1, DEB_CYCLES=4, LONG_CYCLES=20.

- **Reset:** `RST`=1 with `BTN_RAW`=3'b111 (nothing pressed) → all outputs 0 during reset and for 10 cycles after release.
- **Clean short press:** `BTN_RAW[0]` goes 0 for 10 cycles, then 1.
  - `BTN_PRESS[0]` pulses at edge 6 after the fall and `BTN_LEVEL[0]` rises then.
  - After the rise: `BTN_RELEASE[0]` and `BTN_SHORT[0]` pulse together at edge 6. No `BTN_LONG`.
- **Bounce rejection:** `BTN_RAW[1]` toggles 0/1 every 2 cycles for 20 cycles, then stays 1 → no event, `BTN_LEVEL[1]` stays 0.
  - The same bounce followed by a steady 0 → exactly one PRESS, 6 edges after the last transition.
- **Long press:** hold `BTN_RAW[2]`=0 for 40 cycles, then release.
  - Exactly one `BTN_LONG[2]`, 19 edges after PRESS.
  - On release: `BTN_RELEASE[2]` pulses, `BTN_SHORT[2]` stays 0.
- **Boundary:** release timed so the fall lands on the cycle the hold count hits 19 → RELEASE+SHORT, no LONG. Release one cycle later → LONG then RELEASE, no SHORT.
- **Reset mid-press:** assert `RST` while in DOWN, hold the button → no RELEASE. A fresh PRESS occurs 6 edges after `RST` deasserts. Independent channels pressed together → simultaneous, correct per-bit pulses.
